// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared elevator constants, types and hall-call index helpers
package elevator_pkg;

    localparam int NUM_FLOORS = 8;
    localparam int FLOOR_W    = 3;
    localparam int NUM_CALLS  = 16;

    typedef logic [FLOOR_W-1:0]           floor_t;
    typedef logic [$clog2(NUM_CALLS)-1:0] call_idx_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Top-floor up call (7) and ground-floor down call (8) have no button.
    localparam logic [NUM_CALLS-1:0] CALL_LIVE_MASK = 16'hFE7F;

    function automatic floor_t call_floor(input call_idx_t idx);
        return idx[FLOOR_W-1:0];
    endfunction

    function automatic logic call_dir(input call_idx_t idx);
        return idx[FLOOR_W] ? DIR_DOWN : DIR_UP;
    endfunction

endpackage

// File: rtl/hall_call_rr_arb.sv
// rtl/hall_call_rr_arb.sv - combinational 16-way round-robin pick starting at ptr
module hall_call_rr_arb
    import elevator_pkg::*;
(
    input  logic [NUM_CALLS-1:0] req,
    input  call_idx_t            ptr,
    output logic                 any,
    output call_idx_t            idx,
    output logic [NUM_CALLS-1:0] grant
);

    call_idx_t cand;

    always_comb begin
        any   = 1'b0;
        idx   = '0;
        grant = '0;
        cand  = '0;
        for (int i = 0; i < NUM_CALLS; i++) begin
            cand = ptr + call_idx_t'(i);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/hall_call_sequencer.sv
// rtl/hall_call_sequencer.sv - hall buttons to spaced single-cycle floor requests; HALL_CALL_DEBOUNCE_EN enables debounce
module hall_call_sequencer
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int GAP_CYCLES      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn_up,
    input  logic [NUM_FLOORS-1:0] btn_down,
    output logic                  valid_out,
    output logic                  direction,
    output floor_t                req_floor,
    output logic [NUM_CALLS-1:0]  pending
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    logic [NUM_CALLS-1:0] raw, s1, s2, filt, filt_d, rise, grant;
    logic                 any, issue;
    call_idx_t            idx, rr_ptr;
    logic [GAP_W-1:0]     gap_cnt;

    assign raw = {btn_down, btn_up} & CALL_LIVE_MASK;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

`ifdef HALL_CALL_DEBOUNCE_EN
    localparam int TICK_W = $clog2(DEBOUNCE_CYCLES);

    logic [TICK_W-1:0]    tick_cnt;
    logic                 tick;
    logic [NUM_CALLS-1:0] samp, agree;

    assign tick  = (tick_cnt == TICK_W'(DEBOUNCE_CYCLES - 1));
    assign agree = ~(s2 ^ samp);

    // A level is accepted only when two consecutive tick samples match.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            samp     <= '0;
            filt     <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                samp <= s2;
                filt <= (s2 & agree) | (filt & ~agree);
            end
        end
    end
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign filt = s2;
`endif

    assign rise  = filt & ~filt_d;
    assign issue = any && (gap_cnt == '0);

    hall_call_rr_arb u_arb (
        .req   (pending),
        .ptr   (rr_ptr),
        .any   (any),
        .idx   (idx),
        .grant (grant)
    );

    // OR-ing rise after the grant clear lets a same-cycle re-press survive.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_d    <= '0;
            pending   <= '0;
            rr_ptr    <= '0;
            gap_cnt   <= '0;
            valid_out <= 1'b0;
            direction <= DIR_DOWN;
            req_floor <= '0;
        end else begin
            filt_d    <= filt;
            pending   <= (pending & ~(issue ? grant : '0)) | rise;
            valid_out <= issue;
            if (issue) begin
                req_floor <= call_floor(idx);
                direction <= call_dir(idx);
                rr_ptr    <= idx + 1'b1;
                gap_cnt   <= GAP_W'(GAP_CYCLES);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hall_call_sequencer.sv
// tb/tb_hall_call_sequencer.sv - self-checking bench for hall_call_sequencer
`timescale 1ns/1ps
module tb_hall_call_sequencer;

    localparam int DEB    = 4;
    localparam int GAP    = 2;
    localparam int BUDGET = 4 * DEB + 12;
    localparam logic [15:0] LIVE = 16'hFE7F;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] btn_up   = '0;
    logic [7:0] btn_down = '0;
    logic       valid_out, direction;
    logic [2:0] req_floor;
    logic [15:0] pending;

    hall_call_sequencer #(.DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .valid_out (valid_out),
        .direction (direction),
        .req_floor (req_floor),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: filtered level per call, presses arrive as pending
    // one edge after the filtered level rises, round-robin service with a
    // countdown between strobes.
    logic [15:0] m_b1, m_b2, m_samp, m_filt, m_rise_q;
    bit          m_pend [16];
    int          m_ptr, m_gap, m_floor, m_edge;
    bit          m_valid, m_dir;
    bit          m_live = 0;
    int          cyc = 0;
    int          strobe_idx [$];
    int          strobe_cyc [$];

    function automatic logic [15:0] pend_vec();
        logic [15:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[k] = m_pend[k];
        return v;
    endfunction

    always @(posedge clk) begin
        logic [15:0] btn_now, nf;
        int pick;
        cyc++;
        btn_now = {btn_down, btn_up} & LIVE;
        if (reset) begin
            m_b1 = '0; m_b2 = '0; m_samp = '0; m_filt = '0; m_rise_q = '0;
            for (int k = 0; k < 16; k++) m_pend[k] = 0;
            m_ptr = 0; m_gap = 0; m_valid = 0; m_dir = 0; m_floor = 0; m_edge = 0;
            m_live = 1;
        end else begin
            m_edge++;
            m_valid = 0;
            pick = -1;
            if (m_gap == 0)
                for (int n = 0; n < 16; n++)
                    if (pick < 0 && m_pend[(m_ptr + n) % 16]) pick = (m_ptr + n) % 16;
            if (pick >= 0) begin
                m_pend[pick] = 0;
                m_ptr   = (pick + 1) % 16;
                m_gap   = GAP;
                m_valid = 1;
                m_dir   = (pick < 8);
                m_floor = pick % 8;
            end else if (m_gap > 0) begin
                m_gap--;
            end
            for (int k = 0; k < 16; k++) if (m_rise_q[k]) m_pend[k] = 1;
`ifdef HALL_CALL_DEBOUNCE_EN
            nf = m_filt;
            if (m_edge % DEB == 0) begin
                for (int k = 0; k < 16; k++) if (m_b2[k] == m_samp[k]) nf[k] = m_b2[k];
                m_samp = m_b2;
            end
`else
            nf = m_b1;
`endif
            m_rise_q = nf & ~m_filt;
            m_filt   = nf;
            m_b2     = m_b1;
            m_b1     = btn_now;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("model_valid_out", 32'(valid_out), 32'(m_valid));
            check("model_pending",   32'(pending),   32'(pend_vec()));
            check("model_direction", 32'(direction), 32'(m_dir));
            check("model_req_floor", 32'(req_floor), m_floor);
        end
        if (valid_out === 1'b1) begin
            strobe_idx.push_back(int'({~direction, req_floor}));
            strobe_cyc.push_back(cyc);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; btn_up = '0; btn_down = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        strobe_idx.delete();
        strobe_cyc.delete();
    endtask

    typedef struct {
        logic [7:0] up;
        logic [7:0] down;
        int         n;
        int         idx;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int lat;
        int b;

        tbl[0] = '{8'h08, 8'h00, 1, 3};
        tbl[1] = '{8'h00, 8'h20, 1, 13};
        tbl[2] = '{8'h01, 8'h00, 1, 0};
        tbl[3] = '{8'h00, 8'h80, 1, 15};
        tbl[4] = '{8'h80, 8'h01, 0, 0};
        tbl[5] = '{8'h40, 8'h00, 1, 6};

        repeat (2) @(negedge clk);
        check("reset_valid_out", 32'(valid_out), 0);
        check("reset_pending",   32'(pending),   0);
        check("reset_direction", 32'(direction), 0);
        check("reset_req_floor", 32'(req_floor), 0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            btn_up = tbl[v].up; btn_down = tbl[v].down;
            lat = -1;
            for (int c = 1; c <= BUDGET && lat < 0; c++) begin
                @(negedge clk);
                if (valid_out === 1'b1) begin
                    lat = c;
                    check("tbl_pending_cleared", 32'(pending), 0);
                end
            end
            repeat (12) @(negedge clk);
            check("tbl_strobe_count", strobe_idx.size(), tbl[v].n);
            check("tbl_pending_final", 32'(pending), 0);
            if (strobe_idx.size() > 0) check("tbl_index", strobe_idx[0], tbl[v].idx);
`ifndef HALL_CALL_DEBOUNCE_EN
            if (lat >= 0) check("tbl_latency", lat, 4);
`endif
            btn_up = '0; btn_down = '0;
            repeat (3 * DEB) @(negedge clk);
        end

        do_reset();
        btn_up = 8'h41; btn_down = 8'h04;
        repeat (40) @(negedge clk);
        check("simul_count", strobe_idx.size(), 3);
        if (strobe_idx.size() == 3) begin
            check("simul_first",  strobe_idx[0], 0);
            check("simul_second", strobe_idx[1], 6);
            check("simul_third",  strobe_idx[2], 10);
            check("simul_gap_a",  strobe_cyc[1] - strobe_cyc[0], GAP + 1);
            check("simul_gap_b",  strobe_cyc[2] - strobe_cyc[1], GAP + 1);
        end

        do_reset();
        btn_down = 8'h40;
        repeat (30) @(negedge clk);
        btn_down = 8'h00;
        repeat (30) @(negedge clk);
        strobe_idx.delete(); strobe_cyc.delete();
        btn_up = 8'h02; btn_down = 8'h40;
        repeat (30) @(negedge clk);
        check("wrap_count", strobe_idx.size(), 2);
        if (strobe_idx.size() == 2) begin
            check("wrap_first",  strobe_idx[0], 1);
            check("wrap_second", strobe_idx[1], 14);
        end

`ifdef HALL_CALL_DEBOUNCE_EN
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            btn_down[5] = ~btn_down[5];
        end
        @(negedge clk);
        btn_down[5] = 1'b1;
        repeat (50) @(negedge clk);
        check("bounce_count", strobe_idx.size(), 1);
        if (strobe_idx.size() == 1) check("bounce_index", strobe_idx[0], 13);
`endif

        do_reset();
        btn_up = 8'h12; btn_down = 8'h08;
        lat = -1;
        for (int c = 1; c <= BUDGET && lat < 0; c++) begin
            @(negedge clk);
            if (valid_out === 1'b1) lat = c;
        end
        check("midgap_first_strobe_seen", 32'(lat > 0), 1);
        reset = 1'b1;
        @(negedge clk);
        check("midgap_valid_out", 32'(valid_out), 0);
        check("midgap_pending",   32'(pending),   0);
        check("midgap_direction", 32'(direction), 0);
        check("midgap_req_floor", 32'(req_floor), 0);
        strobe_idx.delete(); strobe_cyc.delete();
        repeat (4) @(negedge clk);
        check("midgap_quiet_in_reset", strobe_idx.size(), 0);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        check("midgap_reissue_count", strobe_idx.size(), 3);
        if (strobe_idx.size() == 3) begin
            check("midgap_reissue_a", strobe_idx[0], 1);
            check("midgap_reissue_b", strobe_idx[1], 4);
            check("midgap_reissue_c", strobe_idx[2], 11);
        end

        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                b = $urandom_range(0, 15);
                if (b < 8) btn_up[b] = ~btn_up[b];
                else       btn_down[b - 8] = ~btn_down[b - 8];
            end
            reset = ($urandom_range(0, 499) == 0);
        end
        reset = 1'b0; btn_up = '0; btn_down = '0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hall_call_sequencer.md
# hall_call_sequencer

Upstream stage of the elevator controller: turns sixteen raw hall-call push-buttons into single-cycle floor requests on the controller's `valid_in` / `direction` / `req_floor` input. Each button is synchronised, debounced and edge-detected, then held as a pending call. A round-robin arbiter serialises pending calls one at a time, with a guaranteed minimum spacing between requests, because the controller has no ready signal.

## Interface
- `DEBOUNCE_CYCLES`, default 2_000_000: debounce sample period in `clk` cycles (10 ms at 200 MHz). Must be ≥ 2.
- `GAP_CYCLES`, default 4: idle cycles forced after every issued request. Must be ≥ 1.
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `btn_up`  in  8  raw hall "up" buttons, bit i = floor i. Asynchronous. Bit 7 ignored.
- `btn_down`  in  8  raw hall "down" buttons, bit i = floor i. Asynchronous. Bit 0 ignored.
- `valid_out`  out  1  one-cycle request strobe; drives the controller's `valid_in`.
- `direction`  out  1  1 = up call, 0 = down call; valid when `valid_out` = 1.
- `req_floor`  out  3  requested floor; valid when `valid_out` = 1.
- `pending`  out  16  registered pending-call vector for hall lamps: [7:0] up, [15:8] down.

## Operation
- Call index k: 0–7 = up call at floor k; 8–15 = down call at floor k−8. Indices 7 and 8 are tied off and never become pending.
- Synchroniser: two flops per button (`s1`, `s2`).
- Debounce (`DEBOUNCE_EN`): a shared counter produces `tick` once every `DEBOUNCE_CYCLES` cycles. On `tick`: `samp <= s2`; `filt[k] <= s2[k]` only where `s2[k] == samp[k]` (two agreeing consecutive samples).
- Edge detect: `filt_d <= filt`; `rise = filt & ~filt_d`. Only presses register; releases are ignored.
- Pending: `pending <= (pending & ~grant_mask) | rise`.
  - If the same bit is both granted and risen in one cycle, the rise wins and the bit stays set.
  - A re-press while a call is already pending merges into it; no duplicate request is issued.
- Arbiter: a call issues when `gap_cnt == 0` and `pending != 0`.
  - Select the first set bit at or after `rr_ptr`, wrapping 15→0.
  - Register `valid_out = 1`, `req_floor = idx[2:0]`, `direction = ~idx[3]`.
  - Clear that pending bit, set `rr_ptr <= idx+1` (mod 16) and `gap_cnt <= GAP_CYCLES`.
- Gap counter: decrements by 1 per cycle while nonzero. While `gap_cnt != 0`, no request issues.
- `valid_out` is high for exactly one cycle per request and is 0 in every other cycle. `direction` and `req_floor` hold their last issued value between requests.
- Reset, including mid-sequence: next edge clears `s1`, `s2`, `samp`, `filt`, `filt_d`, `pending`, `rr_ptr`, `gap_cnt` and the tick counter. Outputs become `valid_out=0`, `direction=0`, `req_floor=0`, `pending=0`. Buttons held through reset are seen as new presses once filtered.

## Timing
- Without `DEBOUNCE_EN`: button sampled high at edge N → `pending` bit set after edge N+2 → `valid_out` high after edge N+3, provided `gap_cnt == 0`.
- With `DEBOUNCE_EN`: adds between `DEBOUNCE_CYCLES` and 2·`DEBOUNCE_CYCLES` cycles, depending on tick phase.
- Back-to-back requests are spaced `GAP_CYCLES`+1 cycles apart (strobe to strobe).
- Worst-case service latency for one pending call is 14·(`GAP_CYCLES`+1) cycles (14 live sources, round-robin).

## Configuration
- `HALL_CALL_DEBOUNCE_EN` defined: debounce path, tick counter and `samp`/`filt` registers as above.
- Not defined: `filt = s2` combinationally; no tick counter; `DEBOUNCE_CYCLES` is unused. Intended for simulation and for boards with hardware-debounced buttons.

## Structure
- Shared package `elevator_pkg`:
  - `NUM_FLOORS = 8`, `FLOOR_W = 3`, `NUM_CALLS = 16`
  - `typedef logic [FLOOR_W-1:0] floor_t`
  - `DIR_UP = 1'b1`, `DIR_DOWN = 1'b0`
  - call-index helpers
- One sub-module, `hall_call_rr_arb`: 16-way round-robin priority pick. Inputs: request vector, pointer. Outputs: `any`, index, one-hot grant. Purely combinational.

## Test plan
Bench runs with `DEBOUNCE_CYCLES=4`, `GAP_CYCLES=2`.
- Single press, macro off: `btn_up[3]` high from edge 10 → `valid_out` pulse after edge 13 with `req_floor=3`, `direction=1`; `pending[3]` clears the same edge.
- Bounce, macro on: `btn_down[5]` toggling every cycle for 12 cycles, then stable high → exactly one request (`req_floor=5`, `direction=0`), only after two agreeing ticks.
- Simultaneous presses `btn_up[0]`, `btn_up[6]`, `btn_down[2]` → three strobes in index order 0, 6, 10, spaced 3 cycles apart; no fourth strobe.
- Round-robin wrap: `rr_ptr=15`, pending {1, 14} → index 1 issues first, then 14.
- Tied-off inputs: `btn_up[7]` and `btn_down[0]` held high → no `valid_out`, and `pending` stays 0.
- Reset mid-gap: `reset` asserted the cycle after a strobe, with 2 calls pending → all outputs 0 next edge; no strobes while reset is high; buttons held through reset are re-issued afterwards.
